// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: IR fields and ALU flag in, control strobes/selects out.
// The slave side is the controller, the master side is the datapath.
interface multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             Zero;
  logic             IRWrite;
  logic             PCWrite;
  logic             RegWrite;
  logic             MemWrite;
  logic             MemtoReg;
  logic             RegDst;
  logic             Link;
  logic             Jump;
  logic             JR;
  logic             Branch;
  logic [1:0]       ALUSrc;
  logic [2:0]       ALUControl;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  modport slave (
    input  opcode, funct, Zero,
    output IRWrite, PCWrite, RegWrite, MemWrite, MemtoReg, RegDst, Link, Jump, JR,
           Branch, ALUSrc, ALUControl, illegal, retired
  );

  modport master (
    output opcode, funct, Zero,
    input  IRWrite, PCWrite, RegWrite, MemWrite, MemtoReg, RegDst, Link, Jump, JR,
           Branch, ALUSrc, ALUControl, illegal, retired
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB with a latched instruction class,
// sticky undefined-instruction halt and a retired-instruction counter.
module multicycle_ctrl #(
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  multicycle_ctrl_if.slave   bus
);
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT + 1) : 1;

  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_NOP, C_ADDU, C_SUBU, C_JR, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_ILL
  } cls_t;

  state_t           state_q, state_d;
  cls_t             cls_q, cls_d, dec_cls, sel_cls;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             illegal_q;
  logic [CNT_W-1:0] retired_q;
  logic             ir_we, pc_we, rf_we, dm_we, mem_last;
  logic             unused_zero;

  // Zero only steers the datapath PC mux; the controller pulses PCWrite for beq either way.
  assign unused_zero = bus.Zero;

  always_comb begin
    dec_cls = C_ILL;
    case (bus.opcode)
      6'b000000: begin
        case (bus.funct)
          6'b100001: dec_cls = C_ADDU;
          6'b100011: dec_cls = C_SUBU;
          6'b001000: dec_cls = C_JR;
          6'b000000: dec_cls = C_NOP;
          default:   dec_cls = C_ILL;
        endcase
      end
      6'b001101: dec_cls = C_ORI;
      6'b001111: dec_cls = C_LUI;
      6'b100011: dec_cls = C_LW;
      6'b101011: dec_cls = C_SW;
      6'b000100: dec_cls = C_BEQ;
      6'b000010: dec_cls = C_J;
      6'b000011: dec_cls = C_JAL;
      default:   dec_cls = C_ILL;
    endcase
  end

  assign mem_last = (cnt_q == CW'(MEM_LAT - 1));

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    cnt_d   = cnt_q;
    ir_we   = 1'b0;
    pc_we   = 1'b0;
    rf_we   = 1'b0;
    dm_we   = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_we   = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        cls_d   = dec_cls;
        state_d = (dec_cls == C_ILL) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        case (cls_q)
          C_ADDU, C_SUBU, C_ORI, C_LUI: state_d = S_WB;
          C_LW, C_SW: begin
            cnt_d   = '0;
            state_d = S_MEM;
          end
          C_JAL: begin
            pc_we   = 1'b1;
            rf_we   = 1'b1;
            state_d = S_FETCH;
          end
          default: begin
            pc_we   = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_last) begin
          if (cls_q == C_SW) begin
            dm_we   = 1'b1;
            pc_we   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      cls_q     <= C_NOP;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_q | (state_d == S_HALT);
      if (pc_we) retired_q <= retired_q + 1'b1;
    end
  end

  // DECODE steers selects straight from the decoder since the class register loads at its end.
  assign sel_cls = (state_q == S_DECODE) ? dec_cls : cls_q;

  always_comb begin
    bus.RegDst     = 1'b0;
    bus.ALUSrc     = 2'b00;
    bus.ALUControl = 3'b000;
    bus.MemtoReg   = 1'b0;
    bus.Link       = 1'b0;
    bus.Jump       = 1'b0;
    bus.JR         = 1'b0;
    bus.Branch     = 1'b0;
    if (!reset && state_q != S_FETCH && state_q != S_HALT) begin
      case (sel_cls)
        C_ADDU: bus.RegDst = 1'b1;
        C_SUBU: begin
          bus.RegDst     = 1'b1;
          bus.ALUControl = 3'b001;
        end
        C_ORI: begin
          bus.ALUSrc     = 2'b10;
          bus.ALUControl = 3'b010;
        end
        C_LUI: bus.ALUSrc = 2'b11;
        C_LW: begin
          bus.ALUSrc   = 2'b01;
          bus.MemtoReg = 1'b1;
        end
        C_SW:  bus.ALUSrc = 2'b01;
        C_BEQ: begin
          bus.ALUControl = 3'b001;
          bus.Branch     = 1'b1;
        end
        C_J:   bus.Jump = 1'b1;
        C_JAL: begin
          bus.Jump = 1'b1;
          bus.Link = 1'b1;
        end
        C_JR:  bus.JR = 1'b1;
        default: ;
      endcase
    end
  end

  // Strobes are masked while reset is high so an interrupted instruction never writes.
  assign bus.IRWrite  = ir_we & ~reset;
  assign bus.PCWrite  = pc_we & ~reset;
  assign bus.RegWrite = rf_we & ~reset;
  assign bus.MemWrite = dm_we & ~reset;
  assign bus.illegal  = illegal_q & ~reset;
  assign bus.retired  = reset ? '0 : retired_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Random instruction stream against a per-instruction reference model, scoreboarded at retire,
// followed by directed illegal-halt and mid-instruction reset sequences.
module tb_multicycle_ctrl;
  localparam int ML    = 3;
  localparam int NINST = 300;

  localparam int K_NOP = 0, K_ADDU = 1, K_SUBU = 2, K_JR = 3, K_ORI = 4, K_LUI = 5,
                 K_LW = 6, K_SW = 7, K_BEQ = 8, K_J = 9, K_JAL = 10;

  typedef struct {
    int       cpi;
    int       rw;
    int       mw;
    int       idx;
    bit       src_dc;
    bit [10:0] sel;   // {MemtoReg,RegDst,Link,Jump,JR,Branch,ALUSrc[1:0],ALUControl[2:0]}
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  exp_t exp_q[$];
  int   cyc = 0, rwc = 0, mwc = 0;

  multicycle_ctrl_if #(.CNT_W(32)) bus();
  multicycle_ctrl #(.MEM_LAT(ML), .CNT_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [3:0] strobes();
    return {bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.MemWrite};
  endfunction

  function automatic logic [10:0] sels();
    return {bus.MemtoReg, bus.RegDst, bus.Link, bus.Jump, bus.JR, bus.Branch,
            bus.ALUSrc, bus.ALUControl};
  endfunction

  // Spec-level expectations per instruction: CPI, write pulses, and select values.
  function automatic exp_t model(input int k, input int idx);
    exp_t e;
    e.cpi = 3; e.rw = 0; e.mw = 0; e.idx = idx; e.src_dc = 1'b0; e.sel = '0;
    case (k)
      K_ADDU: begin e.cpi = 4; e.rw = 1; e.sel = 11'b01000000000; end
      K_SUBU: begin e.cpi = 4; e.rw = 1; e.sel = 11'b01000000001; end
      K_JR:   e.sel = 11'b00001000000;
      K_ORI:  begin e.cpi = 4; e.rw = 1; e.sel = 11'b00000010010; end
      K_LUI:  begin e.cpi = 4; e.rw = 1; e.sel = 11'b00000011000; end
      K_LW:   begin e.cpi = 4 + ML; e.rw = 1; e.sel = 11'b10000001000; end
      K_SW:   begin e.cpi = 3 + ML; e.mw = 1; e.sel = 11'b00000001000; end
      K_BEQ:  e.sel = 11'b00000100001;
      K_J:    e.sel = 11'b00010000000;
      K_JAL:  begin e.rw = 1; e.src_dc = 1'b1; e.sel = 11'b00110000000; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic enc(input int k, output logic [5:0] op, output logic [5:0] fn);
    fn = 6'($urandom);
    op = 6'b000000;
    case (k)
      K_NOP:  fn = 6'b000000;
      K_ADDU: fn = 6'b100001;
      K_SUBU: fn = 6'b100011;
      K_JR:   fn = 6'b001000;
      K_ORI:  op = 6'b001101;
      K_LUI:  op = 6'b001111;
      K_LW:   op = 6'b100011;
      K_SW:   op = 6'b101011;
      K_BEQ:  op = 6'b000100;
      K_J:    op = 6'b000010;
      K_JAL:  op = 6'b000011;
      default: ;
    endcase
  endtask

  task automatic wait_fetch(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      bus.Zero = 1'($urandom);
      if (bus.IRWrite) ok = 1'b1;
    end
    if (!ok) check("fetch timeout", 64'(bus.IRWrite), 64'd1);
  endtask

  // Monitor: counts cycles/pulses per instruction and scores it on its PCWrite cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      logic [10:0] got;
      if (bus.IRWrite) begin cyc = 1; rwc = 0; mwc = 0; end
      else cyc++;
      rwc += int'(bus.RegWrite);
      mwc += int'(bus.MemWrite);
      if (bus.PCWrite) begin
        if (exp_q.size() == 0) check("retire without issue", 64'(exp_q.size()), 64'd1);
        else begin
          e = exp_q.pop_front();
          got = sels();
          if (e.src_dc) got[4:3] = e.sel[4:3];
          check("cpi", 64'(cyc), 64'(e.cpi));
          check("regwrite pulses", 64'(rwc), 64'(e.rw));
          check("memwrite pulses", 64'(mwc), 64'(e.mw));
          check("selects", 64'(got), 64'(e.sel));
          check("retired", 64'(bus.retired), 64'(e.idx));
        end
      end
    end
  end

  initial begin
    bit ok;
    logic [5:0] op, fn;
    logic [3:0] acc;
    int k;
    bus.opcode = '0; bus.funct = '0; bus.Zero = 1'b0;
    repeat (3) @(negedge clk);
    check("reset strobes", 64'(strobes()), 64'd0);
    check("reset selects", 64'(sels()), 64'd0);
    check("reset illegal/retired", {31'd0, bus.illegal, bus.retired}, 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    mon_en = 1'b1;

    for (int n = 0; n < NINST; n++) begin
      wait_fetch(ok);
      if (!ok) break;
      k = int'($urandom_range(0, 10));
      enc(k, op, fn);
      bus.opcode = op; bus.funct = fn;
      exp_q.push_back(model(k, n));
    end

    wait_fetch(ok);
    bus.opcode = 6'b111111; bus.funct = 6'($urandom);
    @(negedge clk);
    check("queue drained", 64'(exp_q.size()), 64'd0);
    check("illegal in decode", 64'(bus.illegal), 64'd0);
    @(negedge clk);
    check("illegal in c2", 64'(bus.illegal), 64'd1);
    acc = '0;
    repeat (20) begin
      @(negedge clk);
      acc |= strobes();
    end
    check("halt strobes", 64'(acc), 64'd0);
    check("halt retired frozen", 64'(bus.retired), 64'(NINST));
    check("halt sticky", 64'(bus.illegal), 64'd1);

    mon_en = 1'b0;
    #2 reset = 1'b1;
    #1 check("reset clears halt", {31'd0, bus.illegal, bus.retired}, 64'd0);
    check("reset strobes async", 64'(strobes()), 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("fetch after reset", 64'(strobes()), 64'b1000);
    bus.opcode = 6'b000000; bus.funct = 6'b000000;
    @(negedge clk);
    @(negedge clk);
    check("nop exec pcwrite", 64'(strobes()), 64'b0100);
    @(negedge clk);
    check("retired after nop", 64'(bus.retired), 64'd1);
    bus.opcode = 6'b101011; bus.funct = 6'($urandom);
    repeat (3) @(negedge clk);
    check("sw mem0 strobes", 64'(strobes()), 64'd0);
    @(negedge clk);
    check("sw mem1 strobes", 64'(strobes()), 64'd0);
    #2 reset = 1'b1;
    #1 check("sw reset strobes", 64'(strobes()), 64'd0);
    check("sw reset retired", 64'(bus.retired), 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("fetch after sw reset", 64'(strobes()), 64'b1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
